// File: rtl/mac_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate unit.
// sat_add() is used only when MAC_SAT_EN is defined.
package mac_pkg;

    localparam int MAX_MULT_STAGES = 3;
    localparam int MAX_W           = 64;
    localparam int IDX_W           = $clog2(MAX_W + 1);

    // Product is carried at the widest supported width; users cast it down to their own width.
    typedef struct packed {
        logic             valid;
        logic             first;
        logic [MAX_W-1:0] product;
    } mac_stage_t;

    // Adds two w-bit unsigned values and clamps to all-ones on carry-out of bit w-1.
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W-1:0] acc,
        input logic [MAX_W-1:0] prod,
        input int unsigned      w
    );
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] mask;
        sum  = {1'b0, acc} + {1'b0, prod};
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return sum[IDX_W'(w)] ? mask : (sum[MAX_W-1:0] & mask);
    endfunction

endpackage

// File: rtl/mac_accum_pipe_if.sv
// Sample-in / result-out handshake bundle for mac_accum_pipe.
// master = sample source and result consumer, slave = the MAC block.
interface mac_accum_pipe_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 20
);
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic             first_in;
    logic             valid_in;
    logic             ready_in;
    logic [ACC_W-1:0] f;
    logic             valid_out;
    logic             ready_out;
    logic             overflow;

    modport master (
        output a, b, first_in, valid_in, ready_out,
        input  ready_in, f, valid_out, overflow
    );

    modport slave (
        input  a, b, first_in, valid_in, ready_out,
        output ready_in, f, valid_out, overflow
    );
endinterface

// File: rtl/mac_mult_pipe.sv
// Multiplier followed by MULT_STAGES registers carrying valid/first/product.
// All stages share one enable so the whole line freezes together on a stall.
module mac_mult_pipe
    import mac_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int MULT_STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic            i_first,
    input  logic [IN_W-1:0] i_a,
    input  logic [IN_W-1:0] i_b,
    output mac_stage_t      o_stage
);
    localparam int PROD_W = 2 * IN_W;

    logic [PROD_W-1:0] w_prod;
    mac_stage_t        w_stage0;

    generate
        if (MULT_STAGES < 0 || MULT_STAGES > MAX_MULT_STAGES) begin : g_bad_stages
            $error("mac_mult_pipe: MULT_STAGES out of range");
        end
        if (PROD_W > MAX_W) begin : g_bad_width
            $error("mac_mult_pipe: IN_W too wide for mac_stage_t");
        end
    endgenerate

    assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

    always_comb begin
        w_stage0.valid   = i_valid;
        w_stage0.first   = i_first;
        w_stage0.product = MAX_W'(w_prod);
    end

    genvar gi;
    generate
        if (MULT_STAGES == 0) begin : g_comb
            assign o_stage = w_stage0;
        end else begin : g_regs
            mac_stage_t r_pipe [MULT_STAGES];
            for (gi = 0; gi < MULT_STAGES; gi++) begin : g_stage
                mac_stage_t w_src;
                if (gi == 0) begin : g_head
                    assign w_src = w_stage0;
                end else begin : g_tail
                    assign w_src = r_pipe[gi-1];
                end
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_pipe[gi] <= '0;
                    end else if (i_en) begin
                        r_pipe[gi] <= w_src;
                    end
                end
            end
            assign o_stage = r_pipe[MULT_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mac_accum_pipe.sv
// Pipelined unsigned multiply-accumulate (f += a*b) with valid/ready on both sides,
// per-sample restart and sticky overflow. Define MAC_SAT_EN to clamp instead of wrap.
module mac_accum_pipe
    import mac_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int ACC_W       = 20,
    parameter int MULT_STAGES = 1
) (
    input logic             clk,
    input logic             reset,
    mac_accum_pipe_if.slave bus
);
    logic             w_stall;
    logic             r_in_valid;
    logic             r_in_first;
    logic [IN_W-1:0]  r_in_a;
    logic [IN_W-1:0]  r_in_b;
    mac_stage_t       w_stage;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_valid_out;
    logic             r_overflow;

    generate
        if (ACC_W < 2 * IN_W) begin : g_bad_acc
            $error("mac_accum_pipe: ACC_W must be >= 2*IN_W");
        end
        if (ACC_W > MAX_W) begin : g_wide_acc
            $error("mac_accum_pipe: ACC_W exceeds MAX_W");
        end
    endgenerate

    // An unconsumed result freezes every stage, so ready_in drops in the same cycle.
    assign w_stall       = r_valid_out && !bus.ready_out;
    assign bus.ready_in  = !w_stall;
    assign bus.f         = r_acc;
    assign bus.valid_out = r_valid_out;
    assign bus.overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_valid <= 1'b0;
            r_in_first <= 1'b0;
            r_in_a     <= '0;
            r_in_b     <= '0;
        end else if (!w_stall) begin
            r_in_valid <= bus.valid_in;
            r_in_first <= bus.first_in;
            r_in_a     <= bus.a;
            r_in_b     <= bus.b;
        end
    end

    mac_mult_pipe #(
        .IN_W        (IN_W),
        .MULT_STAGES (MULT_STAGES)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .i_en    (!w_stall),
        .i_valid (r_in_valid),
        .i_first (r_in_first),
        .i_a     (r_in_a),
        .i_b     (r_in_b),
        .o_stage (w_stage)
    );

    assign w_prod = ACC_W'(w_stage.product);
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_prod};

`ifdef MAC_SAT_EN
    assign w_acc_next = ACC_W'(sat_add(MAX_W'(r_acc), MAX_W'(w_prod), ACC_W));
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (!w_stall) begin
            r_valid_out <= w_stage.valid;
            if (w_stage.valid) begin
                if (w_stage.first) begin
                    r_acc      <= w_prod;
                    r_overflow <= 1'b0;
                end else begin
                    r_acc      <= w_acc_next;
                    r_overflow <= r_overflow | w_sum[ACC_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Scoreboard bench for mac_accum_pipe: three instances with MULT_STAGES = 1, 0, 3.
// Expected results are pushed when a sample is accepted and popped on each result handshake.
module tb_mac_accum_pipe;
    localparam int IN_W  = 8;
    localparam int ACC_W = 20;
    localparam int N     = 3;
`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [ACC_W:0] exp_t;   // {f, overflow}

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [IN_W-1:0]  d_a [N];
    logic [IN_W-1:0]  d_b [N];
    logic             d_first [N];
    logic             d_vin [N];
    logic             d_rout [N];
    logic             o_rin [N];
    logic             o_vout [N];
    logic             o_ovf [N];
    logic [ACC_W-1:0] o_f [N];

    exp_t             sb [N][$];
    logic [ACC_W-1:0] m_acc [N];
    logic             m_ovf [N];
    int total = 0;
    int bad   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            localparam int MS = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
            mac_accum_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W)) u_bus ();
            assign u_bus.a         = d_a[gi];
            assign u_bus.b         = d_b[gi];
            assign u_bus.first_in  = d_first[gi];
            assign u_bus.valid_in  = d_vin[gi];
            assign u_bus.ready_out = d_rout[gi];
            assign o_rin[gi]       = u_bus.ready_in;
            assign o_vout[gi]      = u_bus.valid_out;
            assign o_ovf[gi]       = u_bus.overflow;
            assign o_f[gi]         = u_bus.f;
            mac_accum_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_STAGES(MS)) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (u_bus.slave)
            );
        end
    endgenerate

    function automatic void model_push(input int k, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                       input logic first);
        logic [ACC_W-1:0] p;
        logic [ACC_W:0]   s;
        p = ACC_W'(a) * ACC_W'(b);
        if (first) begin
            m_acc[k] = p;
            m_ovf[k] = 1'b0;
        end else begin
            s = {1'b0, m_acc[k]} + {1'b0, p};
            if (s[ACC_W]) begin
                m_ovf[k] = 1'b1;
                m_acc[k] = SAT ? {ACC_W{1'b1}} : s[ACC_W-1:0];
            end else begin
                m_acc[k] = s[ACC_W-1:0];
            end
        end
        sb[k].push_back({m_acc[k], m_ovf[k]});
    endfunction

    // One cycle on instance k: drive at negedge, observe 1 ns later, record acceptance in the model.
    task automatic step(input int k, input logic vin, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                        input logic first, input logic rout, output logic acc, output logic hs);
        @(negedge clk);
        d_vin[k] = vin; d_a[k] = a; d_b[k] = b; d_first[k] = first; d_rout[k] = rout;
        #1;
        acc = vin && o_rin[k];
        hs  = o_vout[k] && rout;
        if (acc) model_push(k, a, b, first);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            total += 4;
            if (o_f[k] !== '0) begin bad++; $display("FAIL reset_f dut%0d: got %0d want 0", k, o_f[k]); end
            if (o_vout[k] !== 1'b0) begin bad++; $display("FAIL reset_vout dut%0d: got %b want 0", k, o_vout[k]); end
            if (o_ovf[k] !== 1'b0) begin bad++; $display("FAIL reset_ovf dut%0d: got %b want 0", k, o_ovf[k]); end
            if (o_rin[k] !== 1'b1) begin bad++; $display("FAIL reset_rin dut%0d: got %b want 1", k, o_rin[k]); end
            m_acc[k] = '0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic test_basic(input int k, input int lat);
        logic acc, hs;
        exp_t e;
        logic [ACC_W-1:0] want [3];
        int n_in = 0, n_out = 0, t_acc = -1, t_hs = -1, t_last = -1;
        want[0] = 20'd9; want[1] = 20'd25; want[2] = 20'd50;
        for (int cyc = 0; cyc < 40 && n_out < 3; cyc++) begin
            step(k, n_in < 3, IN_W'(n_in + 3), IN_W'(n_in + 3), n_in == 0, 1'b1, acc, hs);
            if (acc) begin if (t_acc < 0) t_acc = cyc; n_in++; end
            if (hs) begin
                total += 2;
                if (sb[k].size() == 0) begin
                    bad++; $display("FAIL basic_sb dut%0d: got unexpected f=%0d want none", k, o_f[k]);
                end else begin
                    e = sb[k].pop_front();
                    if ({o_f[k], o_ovf[k]} !== e) begin
                        bad++; $display("FAIL basic_sb dut%0d: got f=%0d ovf=%b want f=%0d ovf=%b", k, o_f[k], o_ovf[k], e[ACC_W:1], e[0]);
                    end
                end
                if (o_f[k] !== want[n_out]) begin
                    bad++; $display("FAIL basic_f dut%0d #%0d: got %0d want %0d", k, n_out, o_f[k], want[n_out]);
                end
                if (t_hs < 0) t_hs = cyc;
                if (t_last >= 0 && cyc != t_last + 1) begin
                    total++; bad++; $display("FAIL basic_gap dut%0d: got result at cycle %0d want %0d", k, cyc, t_last + 1);
                end
                t_last = cyc;
                n_out++;
            end
        end
        total += 2;
        if (n_out != 3) begin bad++; $display("FAIL basic_count dut%0d: got %0d results want 3", k, n_out); end
        if (t_hs - t_acc != lat) begin bad++; $display("FAIL basic_latency dut%0d: got %0d want %0d", k, t_hs - t_acc, lat); end
    endtask

    task automatic test_overflow();
        logic acc, hs;
        exp_t e;
        int n_in = 0, n_out = 0;
        for (int cyc = 0; cyc < 80 && n_out < 17; cyc++) begin
            step(0, n_in < 17, 8'd255, 8'd255, n_in == 0, 1'b1, acc, hs);
            if (acc) n_in++;
            if (hs) begin
                total++;
                if (sb[0].size() == 0) begin
                    bad++; $display("FAIL ovf_sb: got unexpected f=%0d want none", o_f[0]);
                end else begin
                    e = sb[0].pop_front();
                    if ({o_f[0], o_ovf[0]} !== e) begin
                        bad++; $display("FAIL ovf_sb #%0d: got f=%0d ovf=%b want f=%0d ovf=%b", n_out, o_f[0], o_ovf[0], e[ACC_W:1], e[0]);
                    end
                end
                if (n_out == 15) begin
                    total++;
                    if (o_f[0] !== 20'd1040400 || o_ovf[0] !== 1'b0) begin
                        bad++; $display("FAIL ovf_16th: got f=%0d ovf=%b want f=1040400 ovf=0", o_f[0], o_ovf[0]);
                    end
                end
                if (n_out == 16) begin
                    total++;
                    if (o_f[0] !== (SAT ? 20'd1048575 : 20'd56849) || o_ovf[0] !== 1'b1) begin
                        bad++; $display("FAIL ovf_17th: got f=%0d ovf=%b want f=%0d ovf=1", o_f[0], o_ovf[0], SAT ? 1048575 : 56849);
                    end
                end
                n_out++;
            end
        end
        total++;
        if (n_out != 17) begin bad++; $display("FAIL ovf_count: got %0d results want 17", n_out); end
    endtask

    task automatic test_restart();
        logic acc, hs;
        exp_t e;
        logic [IN_W-1:0] sa [2];
        logic [IN_W-1:0] sbv [2];
        logic [ACC_W-1:0] want [2];
        int n_in = 0, n_out = 0;
        sa[0] = 8'd2; sbv[0] = 8'd3; sa[1] = 8'd1; sbv[1] = 8'd1;
        want[0] = 20'd6; want[1] = 20'd7;
        for (int cyc = 0; cyc < 30 && n_out < 2; cyc++) begin
            step(0, n_in < 2, sa[n_in % 2], sbv[n_in % 2], n_in == 0, 1'b1, acc, hs);
            if (acc) n_in++;
            if (hs) begin
                total += 2;
                if (sb[0].size() == 0) begin
                    bad++; $display("FAIL restart_sb: got unexpected f=%0d want none", o_f[0]);
                end else begin
                    e = sb[0].pop_front();
                    if ({o_f[0], o_ovf[0]} !== e) begin
                        bad++; $display("FAIL restart_sb: got f=%0d ovf=%b want f=%0d ovf=%b", o_f[0], o_ovf[0], e[ACC_W:1], e[0]);
                    end
                end
                if (o_f[0] !== want[n_out] || o_ovf[0] !== 1'b0) begin
                    bad++; $display("FAIL restart_f #%0d: got f=%0d ovf=%b want f=%0d ovf=0", n_out, o_f[0], o_ovf[0], want[n_out]);
                end
                n_out++;
            end
        end
        total++;
        if (n_out != 2) begin bad++; $display("FAIL restart_count: got %0d results want 2", n_out); end
    endtask

    task automatic test_stall();
        logic acc, hs, rout;
        exp_t e;
        logic [ACC_W-1:0] f_hold = '0, f_last = '0;
        int n_in = 0, n_out = 0;
        for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
            rout = !(cyc >= 4 && cyc < 8);
            step(0, n_in < 8, IN_W'(n_in + 1), IN_W'(n_in + 1), n_in == 0, rout, acc, hs);
            if (acc) n_in++;
            if (!rout) begin
                total += 2;
                if (o_rin[0] !== 1'b0 || o_vout[0] !== 1'b1) begin
                    bad++; $display("FAIL stall_flags cyc%0d: got ready_in=%b valid_out=%b want 0 1", cyc, o_rin[0], o_vout[0]);
                end
                if (cyc == 4) f_hold = o_f[0];
                else if (o_f[0] !== f_hold) begin
                    bad++; $display("FAIL stall_hold cyc%0d: got f=%0d want %0d", cyc, o_f[0], f_hold);
                end
            end
            if (hs) begin
                total++;
                if (sb[0].size() == 0) begin
                    bad++; $display("FAIL stall_sb: got unexpected f=%0d want none", o_f[0]);
                end else begin
                    e = sb[0].pop_front();
                    if ({o_f[0], o_ovf[0]} !== e) begin
                        bad++; $display("FAIL stall_sb #%0d: got f=%0d ovf=%b want f=%0d ovf=%b", n_out, o_f[0], o_ovf[0], e[ACC_W:1], e[0]);
                    end
                end
                f_last = o_f[0];
                n_out++;
            end
        end
        total += 2;
        if (n_out != 8) begin bad++; $display("FAIL stall_count: got %0d results want 8", n_out); end
        if (f_last !== 20'd204) begin bad++; $display("FAIL stall_final: got f=%0d want 204", f_last); end
    endtask

    task automatic test_reset_flight();
        logic acc, hs;
        step(0, 1'b1, 8'd5, 8'd5, 1'b0, 1'b1, acc, hs);
        step(0, 1'b1, 8'd6, 8'd6, 1'b0, 1'b1, acc, hs);
        @(negedge clk);
        reset = 1'b1;
        d_vin[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total += 3;
        if (o_f[0] !== '0) begin bad++; $display("FAIL flight_f: got %0d want 0", o_f[0]); end
        if (o_vout[0] !== 1'b0) begin bad++; $display("FAIL flight_vout: got %b want 0", o_vout[0]); end
        if (o_ovf[0] !== 1'b0) begin bad++; $display("FAIL flight_ovf: got %b want 0", o_ovf[0]); end
        for (int k = 0; k < N; k++) begin
            sb[k].delete(); m_acc[k] = '0; m_ovf[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            step(0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, hs);
            total++;
            if (o_vout[0] !== 1'b0) begin bad++; $display("FAIL flight_stale cyc%0d: got valid_out=%b want 0", cyc, o_vout[0]); end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            d_a[k] = '0; d_b[k] = '0; d_first[k] = 1'b0; d_vin[k] = 1'b0; d_rout[k] = 1'b1;
        end
        test_reset();
        test_basic(0, 3);
        test_overflow();
        test_restart();
        test_stall();
        test_reset_flight();
        test_basic(1, 2);
        test_basic(2, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
